// File: rtl/tpu_package.sv
// Shared types and constants for the accumulator read-port arbitration slice.
package tpu_package;

   localparam int ACC_MUL_SIZE = 32;
   localparam int ACC_DATA_W   = 32;
   localparam int ACC_ADDR_W   = 10;

   typedef logic [ACC_MUL_SIZE*ACC_DATA_W-1:0] acc_row_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } drain_state_t;

endpackage

// File: rtl/acc_drain_fifo.sv
// First-word-fall-through synchronous FIFO holding drained accumulator rows.
module acc_drain_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/accumulator_read_arbiter.sv
// Shares the accumulator read port between compute (always first) and a
// row-drain engine that streams finished rows into a credit-guarded FIFO.
module accumulator_read_arbiter
   import tpu_package::*;
#(
   parameter int MUL_SIZE   = ACC_MUL_SIZE,
   parameter int DATA_W     = ACC_DATA_W,
   parameter int ADDR_W     = ACC_ADDR_W,
   parameter int RD_LATENCY = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       cmp_rd_i,
   input  logic [ADDR_W-1:0]          cmp_addr_rd_i,
   input  logic                       cmp_wr_i,
   input  logic [ADDR_W-1:0]          cmp_addr_wr_i,
   input  logic                       drain_cmd_valid_i,
   output logic                       drain_cmd_ready_o,
   input  logic [ADDR_W-1:0]          drain_base_i,
   input  logic [ADDR_W:0]            drain_rows_i,
   output logic                       acc_rd_en_o,
   output logic [ADDR_W-1:0]          acc_rd_addr_o,
   input  logic [MUL_SIZE*DATA_W-1:0] acc_rd_data_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [MUL_SIZE*DATA_W-1:0] out_data_o,
   output logic                       out_last_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [15:0]                stall_cnt_o
);

   localparam int ROW_W = MUL_SIZE * DATA_W;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_W:0] ONE_ROW = (ADDR_W + 1)'(1);

   drain_state_t            state_reg, state_next;
   logic [ADDR_W-1:0]       base_reg;
   logic [ADDR_W:0]         rows_reg;
   logic [ADDR_W:0]         cnt_reg;
   logic [15:0]             stall_reg;
   logic [RD_LATENCY-1:0]   pipe_valid_reg;
   logic [RD_LATENCY-1:0]   pipe_last_reg;

   logic [ADDR_W-1:0]       drain_addr;
   logic                    hazard;
   logic                    credit_ok;
   logic                    drain_issue;
   logic                    is_last;
   logic [CNT_W-1:0]        inflight;
   logic [CNT_W:0]          occupancy;
   logic [CNT_W-1:0]        fifo_count;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    fifo_push;
   logic                    fifo_pop;
   logic [ROW_W:0]          fifo_dout;

   assign drain_addr  = base_reg + cnt_reg[ADDR_W-1:0];
   assign is_last     = (cnt_reg == rows_reg - ONE_ROW);
   assign hazard      = cmp_wr_i & (cmp_addr_wr_i == drain_addr);

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + CNT_W'(pipe_valid_reg[i]);
      end
   end

   // Rows already requested but not yet returned still need a FIFO slot.
   assign occupancy   = {1'b0, fifo_count} + {1'b0, inflight};
   assign credit_ok   = (occupancy < DEPTH_C);
   assign drain_issue = (state_reg == ISSUE) & ~cmp_rd_i & ~hazard & credit_ok;

   assign acc_rd_en_o   = cmp_rd_i | drain_issue;
   assign acc_rd_addr_o = cmp_rd_i ? cmp_addr_rd_i : drain_addr;

   assign fifo_pop    = out_ready_i;
   assign fifo_push   = pipe_valid_reg[RD_LATENCY-1] & (~fifo_full | (fifo_pop & ~fifo_empty));
   assign out_valid_o = ~fifo_empty;
   assign out_data_o  = fifo_dout[ROW_W-1:0];
   assign out_last_o  = fifo_dout[ROW_W];

   assign drain_cmd_ready_o = (state_reg == IDLE);
   assign busy_o            = (state_reg != IDLE);
   assign done_o            = (state_reg == DONE);
   assign stall_cnt_o       = stall_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (drain_cmd_valid_i) state_next = (drain_rows_i == '0) ? DONE : ISSUE;
         ISSUE:   if (drain_issue && is_last) state_next = FLUSH;
         FLUSH:   if (out_valid_o && out_ready_i && out_last_o) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg      <= IDLE;
         base_reg       <= '0;
         rows_reg       <= '0;
         cnt_reg        <= '0;
         stall_reg      <= '0;
         pipe_valid_reg <= '0;
         pipe_last_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && drain_cmd_valid_i) begin
            base_reg <= drain_base_i;
            rows_reg <= drain_rows_i;
            cnt_reg  <= '0;
         end else if (drain_issue) begin
            cnt_reg <= cnt_reg + ONE_ROW;
         end
         // Only compute and hazard losses count; credit stalls are the consumer's doing.
         if (state_reg == ISSUE && (cmp_rd_i || hazard) && stall_reg != 16'hFFFF) begin
            stall_reg <= stall_reg + 16'd1;
         end
         pipe_valid_reg[0] <= drain_issue;
         pipe_last_reg[0]  <= drain_issue & is_last;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_valid_reg[i] <= pipe_valid_reg[i-1];
            pipe_last_reg[i]  <= pipe_last_reg[i-1];
         end
      end
   end

   acc_drain_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ROW_W + 1)
   ) u_fifo (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .push  (fifo_push),
      .din   ({pipe_last_reg[RD_LATENCY-1], acc_rd_data_i}),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule
